alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin arbiter that shares one alu_8_bit-style combinational ALU (mode 00 add, 01 and, 10 or, 11 xor) between NUM_REQ requesters. Each requester presents operands and mode with a valid/ready handshake. The winner's operands are muxed onto the ALU inputs. The ALU result is captured in a one-entry response register, tagged with the requester ID, and returned through a valid/ready response port with backpressure.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester ID; must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  bit i: requester i has an operation pending
req_ready  output  NUM_REQ  bit i: requester i's operation accepted this cycle
req_a  input  8*NUM_REQ  operand A; requester i at bits [8i+7:8i]
req_b  input  8*NUM_REQ  operand B; same packing as req_a
req_mode  input  2*NUM_REQ  ALU mode; requester i at bits [2i+1:2i]
alu_a  output  8  operand A to shared ALU
alu_b  output  8  operand B to shared ALU
alu_mode  output  2  mode to shared ALU
alu_z  input  8  combinational ALU result
resp_valid  output  1  response register holds a result
resp_ready  input  1  consumer accepts the response
resp_z  output  8  registered ALU result
resp_id  output  ID_W  index of requester that issued resp_z

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: resp_valid=0, resp_z=8'h00, resp_id=0, last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
- can_accept = !resp_valid | resp_ready.
- Grant (combinational):
  - Among asserted req_valid bits, pick the first index found searching upward from (last_grant+1) mod NUM_REQ, wrapping.
  - No valid bit asserted means no grant.
- Handshake:
  - req_ready[g]=1 only for granted index g, and only when can_accept.
  - All other req_ready bits are 0.
  - A transfer occurs when req_valid[g] & req_ready[g].
- ALU drive (combinational):
  - When a grant exists, alu_a/alu_b/alu_mode = requester g's fields.
  - Otherwise all three are driven to 0.
- On a transfer, at the next clock edge:
  - resp_z <= alu_z; resp_id <= g; resp_valid <= 1; last_grant <= g.
- Latency: exactly 1 cycle from transfer to resp_valid=1 with the result.
- Throughput: 1 operation/cycle while resp_ready=1.
- Response drain: resp_valid & resp_ready with no new transfer means resp_valid <= 0 at the next edge.
- Simultaneous drain and transfer: resp_valid stays 1 and the new result replaces the old in the same edge. No bubble.
- Backpressure: while resp_valid=1 & resp_ready=0:
  - resp_z and resp_id hold stable.
  - All req_ready bits are 0.
  - last_grant does not change.
- Requester rules:
  - A requester must hold its fields stable while req_valid=1 until req_ready.
  - It may deassert req_valid before being granted. The arbiter has no memory of unaccepted requests.
- Fairness: with all requesters continuously valid, grants cycle 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 transfers.
- Arithmetic: add result is 8 bits, carry discarded (8'hFF+8'h01=8'h00). The arbiter never modifies alu_z.
- Reset mid-operation: a pending response is dropped (resp_valid=0 the cycle after rst). req_ready is 0 in every cycle rst=1.
- State: a 2-state machine.
  - EMPTY→FULL on transfer.
  - FULL→EMPTY on drain without transfer.
  - FULL→FULL on drain with transfer, or on stall.

Test Plan:
- Single add: reset, then req_valid=4'b0001, a0=8'h0F, b0=8'h01, mode0=00, resp_ready=1 -> req_ready=4'b0001 that cycle; next cycle resp_valid=1, resp_z=8'h10, resp_id=0.
- Modes and wrap: requester 2 sends a=8'hFF,b=8'h01 in mode 00, then a=8'hF0,b=8'h3C in modes 01/10/11 -> resp_z 8'h00, 8'h30, 8'hFC, 8'hCC, resp_id=2 each time.
- Round-robin: all four valid continuously, resp_ready=1 -> req_ready one-hot sequence 0001,0010,0100,1000,0001; resp_id 0,1,2,3,0 with no idle cycles.
- Skip and wrap: after a grant to 1, only requesters 1 and 3 valid -> grant 3 then 1.
- Backpressure: response held with resp_ready=0 for 3 cycles while requester 0 is valid -> req_ready=0, resp_z/resp_id unchanged for 3 cycles; first cycle resp_ready=1 -> req_ready[0]=1, new result appears next cycle.
- Reset mid-op: assert rst in the cycle after a transfer -> resp_valid=0, resp_z=0 next cycle; first post-reset grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU among NUM_REQ
// requesters, with a one-entry tagged response register.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake (bit i = requester i)
//   req_a/req_b/req_mode  - packed per-requester operands and ALU mode
//   alu_a/alu_b/alu_mode  - winner's operands driven to the shared ALU
//   alu_z                 - combinational ALU result
//   resp_valid/resp_ready - response handshake
//   resp_z/resp_id        - registered result and the requester that issued it
module alu_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2   // must equal $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0] req_mode,
    output logic [7:0]           alu_a,
    output logic [7:0]           alu_b,
    output logic [1:0]           alu_mode,
    input  logic [7:0]           alu_z,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_z,
    output logic [ID_W-1:0]      resp_id
);

    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] resp_z_q, resp_z_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              transfer;
    int unsigned       cand;
    logic [ID_W-1:0]   cand_id;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_id     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand    = (32'(last_grant_q) + i) % NUM_REQ;
            cand_id = ID_W'(cand);
            if (!grant_found && req_valid[cand_id]) begin
                grant_found = 1'b1;
                grant_idx   = cand_id;
            end
        end
    end

    // Accept when the response slot is free or being drained; never in reset.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) || resp_ready;
        transfer   = grant_found && can_accept && !rst;
        req_ready  = '0;
        if (transfer) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    // Winner's operands onto the shared ALU; zeros when idle.
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_mode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_found && (grant_idx == ID_W'(i))) begin
                alu_a    = req_a[i*8 +: 8];
                alu_b    = req_b[i*8 +: 8];
                alu_mode = req_mode[i*2 +: 2];
            end
        end
    end

    // Response slot state machine and capture.
    always_comb begin
        state_d      = state_q;
        resp_z_d     = resp_z_q;
        resp_id_d    = resp_id_q;
        last_grant_d = last_grant_q;

        case (state_q)
            ST_EMPTY: begin
                if (transfer) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (transfer) begin
                    state_d = ST_FULL;
                end else if (resp_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (transfer) begin
            resp_z_d     = alu_z;
            resp_id_d    = grant_idx;
            last_grant_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            resp_z_q     <= '0;
            resp_id_q    <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q      <= state_d;
            resp_z_q     <= resp_z_d;
            resp_id_q    <= resp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_z     = resp_z_q;
    assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural 8-bit ALU in the loop.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_mode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [1:0]  alu_mode;
    logic [7:0]  alu_z;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_z;
    logic [1:0]  resp_id;

    int checks;
    int failures;

    alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_mode  (req_mode),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
        .alu_z     (alu_z),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_z    (resp_z),
        .resp_id   (resp_id)
    );

    // Shared ALU: 00 add (carry dropped), 01 and, 10 or, 11 xor.
    always_comb begin
        case (alu_mode)
            2'b00:   alu_z = alu_a + alu_b;
            2'b01:   alu_z = alu_a & alu_b;
            2'b10:   alu_z = alu_a | alu_b;
            default: alu_z = alu_a ^ alu_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string tag, input logic v, input logic [7:0] z, input logic [1:0] id);
        chk({tag, "_valid"}, 32'(resp_valid), 32'(v));
        chk({tag, "_z"},     32'(resp_z),     32'(z));
        chk({tag, "_id"},    32'(resp_id),    32'(id));
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        req_mode   = '0;
        resp_ready = 1'b0;

        // Reset: no ready while rst is high, registers cleared.
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        chk_resp("rst", 1'b0, 8'h00, 2'd0);

        // Single add from requester 0.
        rst          = 1'b0;
        req_valid    = 4'b0001;
        req_a[7:0]   = 8'h0F;
        req_b[7:0]   = 8'h01;
        req_mode[1:0] = 2'b00;
        resp_ready   = 1'b1;
        #1;
        chk("add_ready", 32'(req_ready), 32'h1);
        chk("add_alu_a", 32'(alu_a), 32'h0F);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_resp("add", 1'b1, 8'h10, 2'd0);
        chk("idle_ready", 32'(req_ready), 32'h0);
        chk("idle_alu_a", 32'(alu_a), 32'h00);
        tick();
        chk("drain_valid", 32'(resp_valid), 32'h0);

        // Requester 2: add wrap, then and/or/xor back-to-back.
        req_valid      = 4'b0100;
        req_a[23:16]   = 8'hFF;
        req_b[23:16]   = 8'h01;
        req_mode[5:4]  = 2'b00;
        #1;
        chk("m_ready", 32'(req_ready), 32'h4);
        tick();
        req_a[23:16]  = 8'hF0;
        req_b[23:16]  = 8'h3C;
        req_mode[5:4] = 2'b01;
        #1;
        chk_resp("m_add", 1'b1, 8'h00, 2'd2);
        chk("m_ready2", 32'(req_ready), 32'h4);
        tick();
        req_mode[5:4] = 2'b10;
        #1;
        chk_resp("m_and", 1'b1, 8'h30, 2'd2);
        tick();
        req_mode[5:4] = 2'b11;
        #1;
        chk_resp("m_or", 1'b1, 8'hFC, 2'd2);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_resp("m_xor", 1'b1, 8'hCC, 2'd2);
        tick();

        // Skip and wrap between requesters 1 and 3.
        req_a[15:8]   = 8'h11;
        req_b[15:8]   = 8'h22;
        req_mode[3:2] = 2'b10;
        req_a[31:24]  = 8'h0F;
        req_b[31:24]  = 8'hF0;
        req_mode[7:6] = 2'b00;
        req_valid     = 4'b0010;
        #1;
        chk("sk_ready1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'b1010;
        #1;
        chk("sk_ready3", 32'(req_ready), 32'h8);
        chk_resp("sk_r1", 1'b1, 8'h33, 2'd1);
        tick();
        #1;
        chk("sk_ready1b", 32'(req_ready), 32'h2);
        chk_resp("sk_r3", 1'b1, 8'hFF, 2'd3);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_resp("sk_r1b", 1'b1, 8'h33, 2'd1);
        tick();

        // Backpressure: hold the response for 3 cycles with requester 0 waiting.
        resp_ready    = 1'b0;
        req_valid     = 4'b0001;
        #1;
        chk("bp_ready0", 32'(req_ready), 32'h1);
        tick();
        req_a[7:0]    = 8'hAA;
        req_b[7:0]    = 8'h55;
        req_mode[1:0] = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk_resp("bp_hold", 1'b1, 8'h10, 2'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_resp("bp_new", 1'b1, 8'hFF, 2'd0);
        tick();

        // Reset right after a transfer, then round-robin from requester 0.
        req_a    = 32'h80_40_10_01;
        req_b    = 32'h80_02_20_02;
        req_mode = 8'h00;
        req_valid = 4'b1111;
        #1;
        chk("rm_ready", 32'(req_ready), 32'h2);
        tick();
        rst = 1'b1;
        #1;
        chk("rm_rst_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk_resp("rm_cleared", 1'b0, 8'h00, 2'd0);
        chk("rr_g0", 32'(req_ready), 32'h1);
        tick();
        chk("rr_g1", 32'(req_ready), 32'h2);
        chk_resp("rr_r0", 1'b1, 8'h03, 2'd0);
        tick();
        chk("rr_g2", 32'(req_ready), 32'h4);
        chk_resp("rr_r1", 1'b1, 8'h30, 2'd1);
        tick();
        chk("rr_g3", 32'(req_ready), 32'h8);
        chk_resp("rr_r2", 1'b1, 8'h42, 2'd2);
        tick();
        chk("rr_g0b", 32'(req_ready), 32'h1);
        chk_resp("rr_r3", 1'b1, 8'h00, 2'd3);
        tick();
        req_valid = 4'b0000;
        #1;
        chk_resp("rr_r0b", 1'b1, 8'h03, 2'd0);
        tick();
        chk("rr_drain", 32'(resp_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
